// File: rtl/mcx_pkg.sv
// rtl/mcx_pkg.sv - shared opcode, condition, flag and register-index constants for mcx_gen
package mcx_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_JMP = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_MUL = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_TEQ = 4'h7;
  localparam logic [3:0] OP_TGT = 4'h8;
  localparam logic [3:0] OP_TLT = 4'h9;
  localparam logic [3:0] OP_SLP = 4'hA;

  localparam logic [1:0] COND_ALWAYS  = 2'b00;
  localparam logic [1:0] COND_PLUS    = 2'b01;
  localparam logic [1:0] COND_MINUS   = 2'b10;
  localparam logic [1:0] COND_ALWAYS2 = 2'b11;

  typedef enum logic [1:0] {
    FLAG_NONE  = 2'd0,
    FLAG_PLUS  = 2'd1,
    FLAG_MINUS = 2'd2
  } flag_e;

  localparam int REG_NULL  = 0;
  localparam int REG_ACC   = 1;
  localparam int REG_DAT   = 2;
  localparam int REG_PORT0 = 3;

endpackage

// File: rtl/mcx_gen_alu.sv
// rtl/mcx_gen_alu.sv - saturating add/sub/mul, not and signed compares; mul only with MCX_GEN_MUL_EN
module mcx_gen_alu
  import mcx_pkg::*;
#(
  parameter int DATA_W  = 11,
  parameter int SAT_MAX = 999
) (
  input  logic [3:0]               op,
  input  logic signed [DATA_W-1:0] acc,
  input  logic signed [DATA_W-1:0] a1,
  input  logic signed [DATA_W-1:0] a2,
  output logic signed [DATA_W-1:0] acc_nxt,
  output logic                     tst
);

  localparam int WW     = 2*DATA_W + 1;
  localparam int HW_MAX = (1 << (DATA_W-1)) - 1;
  localparam int LIM    = (SAT_MAX > HW_MAX) ? HW_MAX : SAT_MAX;
  localparam logic signed [WW-1:0] LIM_P = WW'(LIM);
  localparam logic signed [WW-1:0] LIM_N = -LIM_P;

  logic signed [WW-1:0]     acc_w;
  logic signed [WW-1:0]     a1_w;
  logic signed [WW-1:0]     wide;
  logic signed [DATA_W-1:0] sat;

  assign acc_w = WW'(acc);
  assign a1_w  = WW'(a1);

  // full-precision arithmetic result, wide enough that nothing wraps before clamping
  always_comb begin
    wide = '0;
    case (op)
      OP_ADD: wide = acc_w + a1_w;
      OP_SUB: wide = acc_w - a1_w;
`ifdef MCX_GEN_MUL_EN
      OP_MUL: wide = acc_w * a1_w;
`endif
      default: wide = '0;
    endcase
  end

  // clamp the wide result into the symmetric saturation window
  always_comb begin
    if (wide > LIM_P)      sat = LIM_P[DATA_W-1:0];
    else if (wide < LIM_N) sat = LIM_N[DATA_W-1:0];
    else                   sat = wide[DATA_W-1:0];
  end

  // accumulator update and test outcome per opcode
  always_comb begin
    acc_nxt = acc;
    tst     = 1'b0;
    case (op)
      OP_ADD, OP_SUB: acc_nxt = sat;
`ifdef MCX_GEN_MUL_EN
      OP_MUL:         acc_nxt = sat;
`endif
      OP_NOT:         acc_nxt = (acc == '0) ? LIM_P[DATA_W-1:0] : '0;
      OP_TEQ:         tst = (a1 == a2);
      OP_TGT:         tst = (a1 > a2);
      OP_TLT:         tst = (a1 < a2);
      default:        acc_nxt = acc;
    endcase
  end

endmodule

// File: rtl/mcx_gen.sv
// rtl/mcx_gen.sv - tiny accumulator processor: program store, sequencing, registers, ports (MCX_GEN_MUL_EN enables mul)
module mcx_gen
  import mcx_pkg::*;
#(
  parameter  int DATA_W  = 11,
  parameter  int PC_W    = 4,
  parameter  int NPORTS  = 2,
  parameter  int SAT_MAX = 999,
  localparam int ARG_W   = DATA_W + 1,
  localparam int INST_W  = 6 + 2*ARG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     prog_we,
  input  logic [PC_W-1:0]          prog_addr,
  input  logic [INST_W-1:0]        prog_wdata,
  input  logic [PC_W-1:0]          prog_last,
  input  logic [NPORTS*DATA_W-1:0] p_in,
  output logic [NPORTS*DATA_W-1:0] p_out,
  output logic [NPORTS-1:0]        p_oe,
  output logic [PC_W-1:0]          pc,
  output logic [DATA_W-1:0]        acc_o,
  output logic                     sleeping
);

  logic [INST_W-1:0]        mem [0:(1<<PC_W)-1];
  logic [INST_W-1:0]        line;
  logic [1:0]               cond;
  logic [3:0]               op;
  logic [ARG_W-1:0]         a1;
  logic [ARG_W-1:0]         a2;
  logic signed [DATA_W-1:0] acc;
  logic signed [DATA_W-1:0] dat;
  logic signed [DATA_W-1:0] a1_v;
  logic signed [DATA_W-1:0] a2_v;
  logic signed [DATA_W-1:0] alu_acc;
  logic                     alu_tst;
  logic [DATA_W-1:0]        cnt;
  flag_e                    flag;
  logic                     cond_ok;
  logic                     exec;
  logic                     rd_a1;
  logic                     rd_a2;
  logic                     is_mov;
  logic                     dst_acc;
  logic                     dst_dat;
  logic [NPORTS-1:0]        rd_mask;
  logic [NPORTS-1:0]        wr_mask;
  logic [PC_W-1:0]          pc_seq;

  // value of an operand field: register read or sign-extended immediate
  function automatic logic signed [DATA_W-1:0] arg_val(input logic [ARG_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] acc_v,
                                                       input logic signed [DATA_W-1:0] dat_v,
                                                       input logic [NPORTS*DATA_W-1:0] pin);
    int idx;
    arg_val = '0;
    idx = int'(a[ARG_W-2:0]);
    if (!a[ARG_W-1])          arg_val = $signed(a[DATA_W-1:0]);
    else if (idx == REG_NULL) arg_val = '0;
    else if (idx == REG_ACC)  arg_val = acc_v;
    else if (idx == REG_DAT)  arg_val = dat_v;
    else begin
      for (int k = 0; k < NPORTS; k++)
        if (idx == REG_PORT0 + k) arg_val = $signed(pin[k*DATA_W +: DATA_W]);
    end
  endfunction

  // one-hot port selected by an operand field, empty for immediates and other registers
  function automatic logic [NPORTS-1:0] port_hit(input logic [ARG_W-1:0] a);
    port_hit = '0;
    for (int k = 0; k < NPORTS; k++)
      if (a[ARG_W-1] && int'(a[ARG_W-2:0]) == REG_PORT0 + k) port_hit[k] = 1'b1;
  endfunction

  assign line     = mem[pc];
  assign cond     = line[INST_W-1 -: 2];
  assign op       = line[INST_W-3 -: 4];
  assign a1       = line[2*ARG_W-1 -: ARG_W];
  assign a2       = line[ARG_W-1:0];
  assign a1_v     = arg_val(a1, acc, dat, p_in);
  assign a2_v     = arg_val(a2, acc, dat, p_in);
  assign sleeping = (cnt != '0);
  assign acc_o    = acc;
  assign pc_seq   = (pc == prog_last) ? '0 : pc + PC_W'(1);
  assign exec     = run && !sleeping && cond_ok;
  assign is_mov   = exec && (op == OP_MOV);
  assign dst_acc  = is_mov && a2[ARG_W-1] && (int'(a2[ARG_W-2:0]) == REG_ACC);
  assign dst_dat  = is_mov && a2[ARG_W-1] && (int'(a2[ARG_W-2:0]) == REG_DAT);
  assign wr_mask  = is_mov ? port_hit(a2) : '0;
  assign rd_mask  = exec ? ((rd_a1 ? port_hit(a1) : '0) | (rd_a2 ? port_hit(a2) : '0)) : '0;

  // condition field gates execution on the test flag
  always_comb begin
    case (cond)
      COND_PLUS:                 cond_ok = (flag == FLAG_PLUS);
      COND_MINUS:                cond_ok = (flag == FLAG_MINUS);
      COND_ALWAYS, COND_ALWAYS2: cond_ok = 1'b1;
      default:                   cond_ok = 1'b1;
    endcase
  end

  // which operands an opcode actually reads (drives port drive-enable release)
  always_comb begin
    rd_a1 = 1'b0;
    rd_a2 = 1'b0;
    case (op)
      OP_NOP:                         rd_a1 = 1'b0;
      OP_MOV, OP_ADD, OP_SUB, OP_SLP: rd_a1 = 1'b1;
`ifdef MCX_GEN_MUL_EN
      OP_MUL:                         rd_a1 = 1'b1;
`endif
      OP_TEQ, OP_TGT, OP_TLT: begin
        rd_a1 = 1'b1;
        rd_a2 = 1'b1;
      end
      default:                        rd_a1 = 1'b0;
    endcase
  end

  mcx_gen_alu #(
    .DATA_W  (DATA_W),
    .SAT_MAX (SAT_MAX)
  ) u_alu (
    .op      (op),
    .acc     (acc),
    .a1      (a1_v),
    .a2      (a2_v),
    .acc_nxt (alu_acc),
    .tst     (alu_tst)
  );

  // program store write port; fetch in the same cycle still sees the old line
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_wdata;
  end

  // architectural state: pc, accumulator, dat, flag, sleep countdown and ports
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      acc   <= '0;
      dat   <= '0;
      flag  <= FLAG_NONE;
      cnt   <= '0;
      p_out <= '0;
      p_oe  <= '0;
    end else if (run) begin
      if (sleeping) begin
        cnt <= cnt - DATA_W'(1);
        if (cnt == DATA_W'(1)) pc <= pc_seq;
      end else begin
        pc   <= pc_seq;
        p_oe <= (p_oe & ~rd_mask) | wr_mask;
        for (int k = 0; k < NPORTS; k++)
          if (wr_mask[k]) p_out[k*DATA_W +: DATA_W] <= a1_v;
        if (dst_acc) acc <= a1_v;
        if (dst_dat) dat <= a1_v;
        if (exec) begin
          case (op)
            OP_JMP:                         pc   <= a1[PC_W-1:0];
            OP_ADD, OP_SUB, OP_MUL, OP_NOT: acc  <= alu_acc;
            OP_TEQ, OP_TGT, OP_TLT:         flag <= alu_tst ? FLAG_PLUS : FLAG_MINUS;
            OP_SLP: begin
              if (a1_v > 0) begin
                cnt <= a1_v;
                pc  <= pc;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mcx_gen.sv
// tb/tb_mcx_gen.sv - scoreboard bench for mcx_gen
module tb_mcx_gen;

  localparam int DW = 13;
  localparam int PW = 4;
  localparam int NP = 2;
  localparam int AW = DW + 1;
  localparam int IW = 6 + 2*AW;

  localparam logic [3:0] T_NOP = 4'h0, T_MOV = 4'h1, T_JMP = 4'h2, T_ADD = 4'h3, T_SUB = 4'h4;
  localparam logic [3:0] T_MUL = 4'h5, T_NOT = 4'h6, T_TEQ = 4'h7, T_SLP = 4'hA;
  localparam logic [1:0] C_AL = 2'b00, C_P = 2'b01, C_M = 2'b10;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  run = 1'b0;
  logic                  prog_we = 1'b0;
  logic [PW-1:0]         prog_addr = '0;
  logic [IW-1:0]         prog_wdata = '0;
  logic [PW-1:0]         prog_last = '0;
  logic [NP*DW-1:0]      p_in = '0;
  logic [NP*DW-1:0]      p_out;
  logic [NP-1:0]         p_oe;
  logic [PW-1:0]         pc;
  logic signed [DW-1:0]  acc_o;
  logic                  sleeping;

  mcx_gen #(.DATA_W(DW), .PC_W(PW), .NPORTS(NP), .SAT_MAX(999)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .prog_last  (prog_last),
    .p_in       (p_in),
    .p_out      (p_out),
    .p_oe       (p_oe),
    .pc         (pc),
    .acc_o      (acc_o),
    .sleeping   (sleeping)
  );

  always #5 clk = ~clk;

  typedef enum int {S_PC, S_ACC, S_SLP, S_OE, S_P0, S_P1} sig_e;
  typedef struct {
    string tag;
    sig_e  sig;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  function automatic int observe(input sig_e s);
    case (s)
      S_PC:    return int'(pc);
      S_ACC:   return int'(acc_o);
      S_SLP:   return int'(sleeping);
      S_OE:    return int'(p_oe);
      S_P0:    return int'($signed(p_out[0 +: DW]));
      default: return int'($signed(p_out[DW +: DW]));
    endcase
  endfunction

  task automatic push(input string tag, input sig_e s, input int v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.sig), e.val);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic push_pa(input string tag, input int e_pc, input int e_acc);
    push({tag, ".pc"}, S_PC, e_pc);
    push({tag, ".acc"}, S_ACC, e_acc);
  endtask

  function automatic logic [AW-1:0] imm(input int v);
    return {1'b0, DW'(v)};
  endfunction

  function automatic logic [AW-1:0] rg(input int i);
    return {1'b1, DW'(i)};
  endfunction

  function automatic logic [IW-1:0] ins(input logic [1:0] c, input logic [3:0] o,
                                        input logic [AW-1:0] x1, input logic [AW-1:0] x2);
    return {c, o, x1, x2};
  endfunction

  task automatic put(input int a, input logic [IW-1:0] w);
    prog_we    = 1'b1;
    prog_addr  = PW'(a);
    prog_wdata = w;
    @(posedge clk);
    #1;
    prog_we    = 1'b0;
  endtask

  task automatic reset_and_check(input string tag);
    rst = 1'b1;
    run = 1'b0;
    #1;
    push({tag, ".rst_pc"}, S_PC, 0);
    push({tag, ".rst_acc"}, S_ACC, 0);
    push({tag, ".rst_slp"}, S_SLP, 0);
    push({tag, ".rst_oe"}, S_OE, 0);
    push({tag, ".rst_p0"}, S_P0, 0);
    push({tag, ".rst_p1"}, S_P1, 0);
    drain();
  endtask

  task automatic go(input int last);
    prog_last = PW'(last);
    rst = 1'b0;
    run = 1'b1;
  endtask

  initial begin
    // saturation, pc wrap and run freeze
    reset_and_check("sat");
    put(0, ins(C_AL, T_ADD, imm(600), imm(0)));
    put(1, ins(C_AL, T_ADD, imm(600), imm(0)));
    put(2, ins(C_AL, T_NOT, imm(0), imm(0)));
    put(3, ins(C_AL, T_SUB, imm(2500), imm(0)));
    put(4, ins(C_AL, T_ADD, imm(1000), imm(0)));
    go(4);
    push_pa("sat0", 1, 600);   cyc();
    push_pa("sat1", 2, 999);   cyc();
    push_pa("not", 3, 0);      cyc();
    push_pa("sub", 4, -999);   cyc();
    push_pa("wrap", 0, 1);     cyc();
    push_pa("again", 1, 601);  cyc();
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_pa("frz", 1, 601);
      cyc();
    end

    // test flag, conditional skip and jmp
    reset_and_check("flag");
    put(0, ins(C_AL, T_ADD, imm(5), imm(0)));
    put(1, ins(C_AL, T_TEQ, rg(1), imm(5)));
    put(2, ins(C_P,  T_MOV, imm(1), rg(1)));
    put(3, ins(C_M,  T_MOV, imm(2), rg(1)));
    put(4, ins(C_AL, T_JMP, imm(2), imm(0)));
    go(4);
    push_pa("f_add", 1, 5);    cyc();
    push_pa("f_teq", 2, 5);    cyc();
    push_pa("f_plus", 3, 1);   cyc();
    push_pa("f_skip", 4, 1);   cyc();
    push_pa("f_jmp", 2, 1);    cyc();
    push_pa("f_plus2", 3, 1);  cyc();

    // ports
    reset_and_check("port");
    p_in = {DW'(-7), DW'(123)};
    put(0, ins(C_AL, T_MOV, imm(42), rg(4)));
    put(1, ins(C_AL, T_MOV, rg(4), rg(1)));
    put(2, ins(C_AL, T_MOV, rg(3), rg(3)));
    go(2);
    push("w_p1", S_P1, 42);   push("w_oe", S_OE, 2);   push("w_pc", S_PC, 1);  cyc();
    push("r_acc", S_ACC, -7); push("r_oe", S_OE, 0);   push("r_p1", S_P1, 42); cyc();
    push("rw_p0", S_P0, 123); push("rw_oe", S_OE, 1);  push("rw_pc", S_PC, 0); cyc();

    // sleep countdown and reset during sleep
    reset_and_check("slp");
    put(0, ins(C_AL, T_NOP, imm(0), imm(0)));
    put(1, ins(C_AL, T_NOP, imm(0), imm(0)));
    put(2, ins(C_AL, T_SLP, imm(3), imm(0)));
    put(3, ins(C_AL, T_ADD, imm(9), imm(0)));
    go(3);
    push_pa("s1", 1, 0); push("s1.slp", S_SLP, 0); cyc();
    push_pa("s2", 2, 0); push("s2.slp", S_SLP, 0); cyc();
    for (int i = 0; i < 3; i++) begin
      push_pa("zz", 2, 0);
      push("zz.slp", S_SLP, 1);
      cyc();
    end
    push_pa("wake", 3, 0); push("wake.slp", S_SLP, 0); cyc();
    push_pa("s7", 0, 9);   cyc();
    reset_and_check("slp2");
    go(3);
    cyc(); cyc();
    push("s3.slp", S_SLP, 1); cyc();
    rst = 1'b1;
    #1;
    push("mid.slp", S_SLP, 0); push("mid.pc", S_PC, 0);
    drain();
    rst = 1'b0;
    push("rel.pc", S_PC, 1); push("rel.slp", S_SLP, 0); cyc();

    // multiply build option
    reset_and_check("mul");
    put(0, ins(C_AL, T_ADD, imm(20), imm(0)));
    put(1, ins(C_AL, T_MUL, imm(100), imm(0)));
    go(1);
    push_pa("m_add", 1, 20); cyc();
`ifdef MCX_GEN_MUL_EN
    push_pa("m_mul", 0, 999); cyc();
`else
    push_pa("m_mul", 0, 20); cyc();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mcx_gen.md
MCX_GEN -- requirements
Module: mcx_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 11: signed data width of acc, dat and ports.
REQ-002 SHALL have parameter PC_W, default 4: program store holds 2^PC_W lines.
REQ-003 SHALL have parameter NPORTS, default 2, range 1-8: number of simple I/O ports.
REQ-004 SHALL have parameter SAT_MAX, default 999: saturation limit, clamped to 2^(DATA_W-1)-1.
REQ-005 SHALL derive ARG_W=DATA_W+1 and INST_W=6+2*ARG_W; line = [cond 2][op 4][a1 ARG_W][a2 ARG_W], MSB first.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 run  input  1  execute enable; 0 freezes all architectural state except the program store.
REQ-009 prog_we  input  1  program store write strobe.
REQ-010 prog_addr  input  PC_W  program store write address.
REQ-011 prog_wdata  input  INST_W  program line to write.
REQ-012 prog_last  input  PC_W  index of the last program line; PC wraps after it.
REQ-013 p_in  input  NPORTS*DATA_W  port read values, port k at [k*DATA_W +: DATA_W].
REQ-014 p_out  output  NPORTS*DATA_W  registered port write values.
REQ-015 p_oe  output  NPORTS  per-port drive enable.
REQ-016 pc  output  PC_W  address of the line executing this cycle.
REQ-017 acc_o  output  DATA_W  accumulator value.
REQ-018 sleeping  output  1  high while a slp countdown is active.

Function
REQ-019 SHALL read the line at pc combinationally and retire one instruction per cycle when run=1 and sleeping=0.
REQ-020 SHALL decode an argument with MSB=1 as register index (0 null=0, 1 acc, 2 dat, 3+k port k); other indices read as 0. An argument with MSB=0 is an immediate: low DATA_W bits, signed.
REQ-021 SHALL implement opcodes 0 nop, 1 mov a1->a2, 2 jmp a1[PC_W-1:0], 3 add, 4 sub, 5 mul (acc=acc op a1), 6 not (acc=SAT_MAX if acc==0 else 0), 7 teq, 8 tgt, 9 tlt (compare a1 with a2), A slp a1; B-F execute as nop.
REQ-022 SHALL clamp every add/sub/mul result to [-SAT_MAX, +SAT_MAX], computed at 2*DATA_W+1 bits before clamping.
REQ-023 SHALL keep a flag in {NONE, PLUS, MINUS}: a test sets PLUS if true, MINUS if false; NONE only after reset.
REQ-024 SHALL use cond 00 = always, 01 = execute only if flag==PLUS, 10 = only if MINUS, 11 = always; a skipped line advances pc only.
REQ-025 SHALL set next pc = jmp target if an executed jmp, else 0 if pc==prog_last, else pc+1; a jmp target above prog_last executes as written.
REQ-026 SHALL, on executed mov to port k, load p_out[k] and set p_oe[k]=1 from the next cycle; an executed instruction reading port k clears p_oe[k]; a simultaneous read and write of port k leaves p_oe[k]=1.
REQ-027 SHALL, on executed mov to null or to an immediate destination, discard the value.
REQ-028 SHALL, on slp with a1>0, load a countdown with a1 and assert sleeping next cycle, decrementing each run=1 cycle, then resume at pc+1 (or wrap) when it reaches 0; a1<=0 behaves as nop.
REQ-029 SHALL write prog_wdata to prog_addr on any clk edge with prog_we=1, regardless of run; a same-cycle fetch of that address sees the old line.

Reset
REQ-030 SHALL on rst drive pc=0, acc=0, dat=0, flag=NONE, countdown=0, sleeping=0, p_out=0, p_oe=0 immediately; the program store is not reset.
REQ-031 SHALL abort any in-progress slp on reset; the first fetch after release is line 0.

Configuration
REQ-032 SHALL, with macro MCX_GEN_MUL_EN defined, implement opcode 5 per REQ-021/022; without it, opcode 5 executes as nop and no multiplier is synthesised.

Structure
REQ-033 SHALL put opcode, cond codes, flag enum and register index constants in shared package mcx_pkg.
REQ-034 SHALL place arithmetic, compare and saturation in sub-module mcx_gen_alu; mcx_gen holds sequencing, registers and ports.

Verification
REQ-035 add 600 twice from acc=0 -> acc_o 600 then 999 (saturated); sub 2500 from 0 -> -999.
REQ-036 teq acc,5 with acc=5, next two lines "+ mov 1,acc" and "- mov 2,acc" -> acc=1 and the second line is skipped with pc still advancing.
REQ-037 mov 42,p1 -> p_out[1]=42, p_oe=2'b10 next cycle; then mov p1,acc with p_in[1]=-7 -> acc=-7, p_oe[1]=0.
REQ-038 slp 3 at pc=2 -> sleeping high 3 cycles, pc holds 2, then pc=3; rst asserted mid-sleep -> sleeping=0, pc=0 at once.
REQ-039 prog_last=4, no jmp -> pc sequence 0,1,2,3,4,0; jmp 2 at pc=4 -> pc=2; run=0 for 5 cycles -> pc, acc unchanged.
REQ-040 mul 100 with acc=20, with and without MCX_GEN_MUL_EN -> acc=999 vs acc=20.
